// File: rtl/wburst_pkg.sv
// Shared types and default geometry for the write-data burst manager.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wburst_pkg;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_BURST = 1'b1
    } wb_state_t;

    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BEATS_DEF = 4;
    localparam int ID_W_DEF      = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int Q_DEPTH_DEF   = 2;

    localparam int STRB_W = DATA_W_DEF / 8;
    localparam int LEN_W  = $clog2(MAX_BEATS_DEF);
    localparam int ENT_W  = ID_W_DEF + ADDR_W_DEF + LEN_W + MAX_BEATS_DEF * (DATA_W_DEF + STRB_W);

endpackage

// File: rtl/wburst_req_fifo.sv
// Request queue: synchronous FIFO exposing its head entry directly.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: pushes while full and pops while empty are dropped.
module wburst_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wdata_burst_mngr.sv
// Write-data channel master: queues burst requests and streams their beats back-to-back.
// Latency: push into an empty queue drives wvalid the next cycle; no bubble between bursts.
// Backpressure: beats hold stable under wready=0; next_rdy drops when the queue is full.
module wdata_burst_mngr
    import wburst_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int Q_DEPTH   = Q_DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              wvalid,
    input  logic                              wready,
    output logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W/8-1:0]               wstrb,
    output logic                              wlast,
    input  logic                              next_rq,
    output logic                              next_rdy,
    input  logic [ID_W-1:0]                   next_id,
    input  logic [ADDR_W-1:0]                 next_addr,
    input  logic [$clog2(MAX_BEATS)-1:0]      next_len,
    input  logic [DATA_W*MAX_BEATS-1:0]       in_wdata,
    input  logic [DATA_W/8*MAX_BEATS-1:0]     in_wstrb,
    output logic                              finish_wd,
    output logic [ID_W-1:0]                   finish_id,
    output logic [ADDR_W-1:0]                 finish_addr,
    output logic                              busy
);
    localparam int SW   = DATA_W / 8;
    localparam int LW   = $clog2(MAX_BEATS);
    localparam int EW   = ID_W + ADDR_W + LW + MAX_BEATS * (DATA_W + SW);
    localparam int CW   = $clog2(Q_DEPTH) + 1;
    // Entry layout, LSB first: strobes, data, len, addr, id.
    localparam int DOFF = MAX_BEATS * SW;
    localparam int LOFF = DOFF + MAX_BEATS * DATA_W;
    localparam int AOFF = LOFF + LW;
    localparam int IOFF = AOFF + ADDR_W;

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [EW-1:0]     head;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_cnt;
    logic              push_ok;
    logic              beat;
    logic [LW-1:0]     beat_cnt;
    logic [LW-1:0]     head_len;
    logic [DATA_W-1:0] beat_dat [MAX_BEATS];
    logic [SW-1:0]     beat_stb [MAX_BEATS];

    assign next_rdy    = ~q_full;
    assign push_ok     = next_rq & next_rdy;
    assign busy        = ~q_empty;
    assign head_len    = head[LOFF +: LW];
    assign finish_id   = head[IOFF +: ID_W];
    assign finish_addr = head[AOFF +: ADDR_W];
    assign beat        = wvalid & wready;
    assign finish_wd   = beat & wlast;

    for (genvar k = 0; k < MAX_BEATS; k++) begin : g_beat
        assign beat_dat[k] = head[DOFF + k*DATA_W +: DATA_W];
        assign beat_stb[k] = head[k*SW +: SW];
    end

    wburst_req_fifo #(
        .W     (EW),
        .DEPTH (Q_DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_ok),
        .push_dat ({next_id, next_addr, next_len, in_wdata, in_wstrb}),
        .pop      (finish_wd),
        .head_dat (head),
        .full     (q_full),
        .empty    (q_empty),
        .cnt      (q_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= WB_IDLE;
        else     state <= state_nxt;
    end

    // A push seen in IDLE starts the burst next cycle; the last pop only idles if nothing refills.
    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE:  if (push_ok || !q_empty) state_nxt = WB_BURST;
            WB_BURST: if (finish_wd && q_cnt == CW'(1) && !push_ok) state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        wvalid = (state == WB_BURST);
        wlast  = wvalid & (beat_cnt == head_len);
        wdata  = beat_dat[beat_cnt];
        wstrb  = beat_stb[beat_cnt];
    end

    always_ff @(posedge clk) begin
        if (rst)       beat_cnt <= '0;
        else if (beat) beat_cnt <= wlast ? '0 : beat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_wdata_burst_mngr.sv
// Bench for wdata_burst_mngr: fixed vector table, directed corner sequences, random run vs queue model.
module tb_wdata_burst_mngr;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 4;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int Q_DEPTH   = 2;
    localparam int STRB_W    = DATA_W / 8;
    localparam int LEN_W     = $clog2(MAX_BEATS);
    localparam int NV        = 17;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          wvalid, wready, wlast;
    logic [DATA_W-1:0]             wdata;
    logic [STRB_W-1:0]             wstrb;
    logic                          next_rq, next_rdy;
    logic [ID_W-1:0]               next_id;
    logic [ADDR_W-1:0]             next_addr;
    logic [LEN_W-1:0]              next_len;
    logic [DATA_W*MAX_BEATS-1:0]   in_wdata;
    logic [STRB_W*MAX_BEATS-1:0]   in_wstrb;
    logic                          finish_wd;
    logic [ID_W-1:0]               finish_id;
    logic [ADDR_W-1:0]             finish_addr;
    logic                          busy;

    always #5 clk = ~clk;

    wdata_burst_mngr #(
        .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ID_W(ID_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .next_rq(next_rq), .next_rdy(next_rdy), .next_id(next_id),
        .next_addr(next_addr), .next_len(next_len), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
        .finish_wd(finish_wd), .finish_id(finish_id), .finish_addr(finish_addr), .busy(busy)
    );

    typedef struct {
        logic [ID_W-1:0]             id;
        logic [ADDR_W-1:0]           addr;
        logic [LEN_W-1:0]            len;
        logic [DATA_W*MAX_BEATS-1:0] d;
        logic [STRB_W*MAX_BEATS-1:0] s;
    } req_t;

    typedef struct {
        logic        rq;
        logic        wr;
        logic        v;
        logic        l;
        logic [31:0] d;
        logic        f;
        logic        b;
        logic        r;
    } vec_t;

    req_t            mq[$];
    int              idx;
    logic [ID_W-1:0] fin_ids[$];
    int              checks;
    int              errors;
    int              proto_err;
    vec_t            tv[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                input logic [LEN_W-1:0] len, input bit rnd);
        req_t r;
        r.id = id; r.addr = addr; r.len = len;
        for (int k = 0; k < MAX_BEATS; k++) begin
            r.d[k*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : DATA_W'(32'h1111_1111 * (k + 1));
            r.s[k*STRB_W +: STRB_W] = rnd ? STRB_W'($urandom) : '1;
        end
        return r;
    endfunction

    task automatic drive(input logic rq, input req_t r, input logic rdy, input logic do_rst);
        next_rq = rq; next_id = r.id; next_addr = r.addr; next_len = r.len;
        in_wdata = r.d; in_wstrb = r.s; wready = rdy; rst = do_rst;
    endtask

    // Model: the head burst is on the bus whenever the queue holds anything.
    task automatic check_model();
        logic v;
        logic l;
        v = (mq.size() > 0);
        chk("wvalid", wvalid, v);
        chk("busy", busy, v);
        chk("next_rdy", next_rdy, mq.size() < Q_DEPTH);
        if (v) begin
            l = (idx == int'(mq[0].len));
            chk("wdata", wdata, mq[0].d[idx*DATA_W +: DATA_W]);
            chk("wstrb", wstrb, mq[0].s[idx*STRB_W +: STRB_W]);
            chk("wlast", wlast, l);
            chk("finish_wd", finish_wd, l & wready);
            if (l & wready) begin
                chk("finish_id", finish_id, mq[0].id);
                chk("finish_addr", finish_addr, mq[0].addr);
            end
        end else begin
            chk("wlast_idle", wlast, 1'b0);
            chk("finish_idle", finish_wd, 1'b0);
        end
    endtask

    task automatic advance();
        bit   beat, last, push, was_rst;
        req_t r;
        push    = next_rq && (mq.size() < Q_DEPTH);
        if (next_rq && !push) proto_err++;
        beat    = (mq.size() > 0) && wready;
        last    = beat && (idx == int'(mq[0].len));
        was_rst = rst;
        r.id = next_id; r.addr = next_addr; r.len = next_len; r.d = in_wdata; r.s = in_wstrb;
        if (last) fin_ids.push_back(mq[0].id);
        @(posedge clk);
        #1;
        if (was_rst) begin
            mq.delete();
            idx = 0;
        end else begin
            if (beat) begin
                if (last) begin
                    mq.delete(0);
                    idx = 0;
                end else idx++;
            end
            if (push) mq.push_back(r);
        end
    endtask

    task automatic cyc(input logic rq, input req_t r, input logic rdy, input logic do_rst);
        drive(rq, r, rdy, do_rst);
        #1;
        check_model();
        advance();
    endtask

    initial begin
        req_t zr, ra, rb, rc, rd, re, rf, rg, rh, ri, rj, rr;
        checks = 0; errors = 0; proto_err = 0; idx = 0;
        zr = '{id: '0, addr: '0, len: '0, d: '0, s: '0};
        ra = mk(4'd3, 32'h1000, 2'd3, 1'b0);

        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b1, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11111111, 1'b0, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b1, 1'b1};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b1, 1'b1};
        tv[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h33333333, 1'b0, 1'b1, 1'b1};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1};
        tv[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 1'b1};
        tv[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};

        // Reset state
        drive(1'b0, zr, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b0, zr, 1'b0, 1'b0);
        #1;
        chk("rst wvalid", wvalid, 1'b0);
        chk("rst wlast", wlast, 1'b0);
        chk("rst finish_wd", finish_wd, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst next_rdy", next_rdy, 1'b1);
        chk("rst wdata", wdata, '0);
        chk("rst wstrb", wstrb, '0);
        chk("rst finish_id", finish_id, '0);
        chk("rst finish_addr", finish_addr, '0);

        // Single burst, then the same burst under wready backpressure
        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rq, ra, tv[i].wr, 1'b0);
            #1;
            chk($sformatf("tv%0d wvalid", i), wvalid, tv[i].v);
            chk($sformatf("tv%0d wlast", i), wlast, tv[i].l);
            chk($sformatf("tv%0d finish_wd", i), finish_wd, tv[i].f);
            chk($sformatf("tv%0d busy", i), busy, tv[i].b);
            chk($sformatf("tv%0d next_rdy", i), next_rdy, tv[i].r);
            if (tv[i].v) begin
                chk($sformatf("tv%0d wdata", i), wdata, tv[i].d);
                chk($sformatf("tv%0d wstrb", i), wstrb, 4'hF);
            end
            if (tv[i].f) begin
                chk($sformatf("tv%0d finish_id", i), finish_id, 4'd3);
                chk($sformatf("tv%0d finish_addr", i), finish_addr, 32'h1000);
            end
            advance();
        end

        // Back-to-back: len=1 then len=0, no gaps
        rb = mk(4'd1, 32'h2000, 2'd1, 1'b1);
        rc = mk(4'd2, 32'h3000, 2'd0, 1'b1);
        fin_ids.delete();
        cyc(1'b1, rb, 1'b1, 1'b0);
        cyc(1'b1, rc, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, zr, 1'b1, 1'b0);
        chk("b2b busy", busy, 1'b0);
        chk("b2b finishes", fin_ids.size(), 2);
        if (fin_ids.size() == 2) begin
            chk("b2b id0", fin_ids[0], 4'd1);
            chk("b2b id1", fin_ids[1], 4'd2);
        end

        // Full queue: third push ignored, next_rdy returns after the first wlast beat
        rd = mk(4'd7, 32'h7000, 2'd1, 1'b1);
        re = mk(4'd8, 32'h8000, 2'd0, 1'b1);
        rf = mk(4'd9, 32'h9000, 2'd2, 1'b1);
        fin_ids.delete();
        cyc(1'b1, rd, 1'b0, 1'b0);
        cyc(1'b1, re, 1'b0, 1'b0);
        drive(1'b1, rf, 1'b0, 1'b0);
        #1;
        chk("full next_rdy", next_rdy, 1'b0);
        check_model();
        advance();
        cyc(1'b0, zr, 1'b1, 1'b0);
        cyc(1'b0, zr, 1'b1, 1'b0);
        drive(1'b0, zr, 1'b1, 1'b0);
        #1;
        chk("full rdy after pop", next_rdy, 1'b1);
        check_model();
        advance();
        for (int i = 0; i < 3; i++) cyc(1'b0, zr, 1'b1, 1'b0);
        chk("full finishes", fin_ids.size(), 2);
        if (fin_ids.size() == 2) chk("full last id", fin_ids[1], 4'd8);

        // Push in the same cycle as the only entry's wlast handshake
        rg = mk(4'd5, 32'h5500, 2'd0, 1'b1);
        rh = mk(4'd6, 32'h6600, 2'd1, 1'b1);
        cyc(1'b1, rg, 1'b1, 1'b0);
        cyc(1'b1, rh, 1'b1, 1'b0);
        drive(1'b0, zr, 1'b1, 1'b0);
        #1;
        chk("pp wvalid", wvalid, 1'b1);
        chk("pp head id", finish_id, 4'd6);
        chk("pp wdata", wdata, rh.d[DATA_W-1:0]);
        check_model();
        advance();
        for (int i = 0; i < 2; i++) cyc(1'b0, zr, 1'b1, 1'b0);

        // Reset after beat 2 of 4
        ri = mk(4'd10, 32'hA000, 2'd3, 1'b1);
        rj = mk(4'd11, 32'hB000, 2'd1, 1'b1);
        cyc(1'b1, ri, 1'b1, 1'b0);
        cyc(1'b0, zr, 1'b1, 1'b0);
        cyc(1'b0, zr, 1'b1, 1'b0);
        cyc(1'b0, zr, 1'b0, 1'b1);
        drive(1'b0, zr, 1'b1, 1'b0);
        #1;
        chk("mrst wvalid", wvalid, 1'b0);
        chk("mrst busy", busy, 1'b0);
        chk("mrst next_rdy", next_rdy, 1'b1);
        chk("mrst finish_wd", finish_wd, 1'b0);
        advance();
        cyc(1'b1, rj, 1'b1, 1'b0);
        drive(1'b0, zr, 1'b1, 1'b0);
        #1;
        chk("mrst restart wdata", wdata, rj.d[DATA_W-1:0]);
        check_model();
        advance();
        for (int i = 0; i < 2; i++) cyc(1'b0, zr, 1'b1, 1'b0);

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            logic rq;
            rr = mk(ID_W'($urandom), ADDR_W'($urandom), LEN_W'($urandom), 1'b1);
            rq = (mq.size() < Q_DEPTH) && ($urandom_range(0, 2) != 0);
            cyc(rq, rr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdata_burst_mngr.md
Name: wdata_burst_mngr

Overview:
Parametrised successor to the single-request write data channel manager. Drives the write data channel of the bus master: queues up to Q_DEPTH write requests, each carrying id, address, burst length and a full data/strobe payload. Bursts stream out back-to-back with no idle cycle between them. Sits between the master's write-request logic and the bus. Per burst, reports id/address completion on the last-beat handshake.

Parameters:
DATA_W, 32, bus data width in bits; multiple of 8.
MAX_BEATS, 4, maximum beats per burst; power of 2, >= 2.
ID_W, 4, transaction id width.
ADDR_W, 32, address width.
Q_DEPTH, 2, request queue entries; power of 2, >= 1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wvalid  out  1  write data valid
wready  in  1  write data ready
wdata  out  DATA_W  beat data
wstrb  out  DATA_W/8  beat byte strobes
wlast  out  1  final beat of burst
next_rq  in  1  request push strobe
next_rdy  out  1  queue can accept a request
next_id  in  ID_W  request id
next_addr  in  ADDR_W  request address
next_len  in  clog2(MAX_BEATS)  beats minus 1
in_wdata  in  DATA_W*MAX_BEATS  payload; beat k = bits [k*DATA_W +: DATA_W]
in_wstrb  in  DATA_W/8*MAX_BEATS  strobes; beat k sliced likewise
finish_wd  out  1  last-beat handshake pulse
finish_id  out  ID_W  id of completing burst
finish_addr  out  ADDR_W  address of completing burst
busy  out  1  queue non-empty

Behaviour:
- Clock and reset: one clock clk. rst is synchronous and active-high. Sampled high at a clk edge, it empties the queue, zeroes beat_cnt and returns the FSM to IDLE.
- Reset values: wvalid=0, wlast=0, finish_wd=0, busy=0, next_rdy=1. wdata, wstrb, finish_id and finish_addr read 0, since all queue storage is cleared.
- Reset mid-burst: the burst is abandoned. wvalid is 0 in the cycle after rst, and no finish_wd is generated for it.
- Push: on next_rq & next_rdy, {next_id, next_addr, next_len, in_wdata, in_wstrb} is written at the tail.
- next_rq while next_rdy=0 is ignored; the bench flags it as a protocol error.
- next_rdy = !full. It is combinational from registered state only, with no dependence on a pop in the same cycle.
- Beat handshake: beat = wvalid & wready.
- beat_cnt, width clog2(MAX_BEATS), indexes the head entry. wdata and wstrb are the beat_cnt slice of the head payload.
- wlast = wvalid & (beat_cnt == head.len).
- FSM states and transitions:
  - IDLE: wvalid=0. Go to BURST when the queue is non-empty.
  - BURST: wvalid=1, beat_cnt counts up by 1 on each beat.
  - On a beat with wlast=1: pop the head, reset beat_cnt to 0. Stay in BURST if the queue is still non-empty after the pop (a simultaneous push counts); otherwise go to IDLE.
- AXI stability: while wvalid=1 and wready=0, wdata, wstrb and wlast hold constant. A push never alters the head entry.
- Latency: a push into an empty queue gives wvalid=1 on the next cycle.
- Back-to-back bursts: the beat after a wlast handshake is driven in the following cycle with no bubble.
- next_len=0: single-beat burst, wlast=1 on the first beat.
- Completion: finish_wd = wvalid & wready & wlast, combinational. finish_id and finish_addr always show the head entry, so they are valid while finish_wd=1.
- Simultaneous push and pop:
  - Both occur in the same cycle; the count is unchanged.
  - When full, next_rdy is already 0, so no push occurs.
- Pointers wrap modulo Q_DEPTH. The count register is clog2(Q_DEPTH)+1 bits.
- busy = (count != 0).

Decomposition:
- Shared package wburst_pkg holds:
  - FSM encodings WB_IDLE and WB_BURST.
  - Localparams STRB_W = DATA_W/8, LEN_W = clog2(MAX_BEATS), ENT_W = ID_W+ADDR_W+LEN_W+MAX_BEATS*(DATA_W+STRB_W).
- One sub-module, wburst_req_fifo:
  - Synchronous FIFO, parametrised width ENT_W and depth Q_DEPTH.
  - Ports: push, pop, full, empty, head data.
  - Synchronous active-high reset clears storage.

Test Plan:
- Single 4-beat burst: push id=3, addr=0x1000, len=3, in_wdata words 0x11111111..0x44444444, wready held 1 → wvalid rises the cycle after the push. wdata sequence is 0x11111111, 0x22222222, 0x33333333, 0x44444444. wlast is high on beat 4 only. One finish_wd with finish_id=3, finish_addr=0x1000.
- Backpressure: same burst with wready toggling 0,1,0,0,1,... → wdata, wstrb and wlast stable during every wready=0 cycle. Exactly 4 beats complete.
- Back-to-back: push len=1 (id=1) and len=0 (id=2) in consecutive cycles, wready=1 → 3 consecutive beats with no gap. wlast on beats 2 and 3. finish_wd pulses with id 1 then id 2. busy falls after beat 3.
- Full queue, Q_DEPTH=2: push 2 requests with wready=0 → next_rdy=0. A third next_rq is ignored. The first wlast beat raises next_rdy the following cycle.
- Push coinciding with pop: with 1 entry queued, push in the same cycle as its wlast handshake → the new burst's beat 0 is driven the next cycle with no IDLE state.
- Reset mid-burst: assert rst after beat 2 of 4 → next cycle wvalid=0, busy=0, next_rdy=1, no finish_wd. A subsequent push starts at beat 0.
